line_buffer_tile_ctrl: RTL and testbench
========================================

// Module: line_buffer_tile_ctrl
// PURPOSE
//  Sequences one line_buffer instance over a frame processed in row bands.
//  Per band: gates M*W upstream pixels into the buffer, then issues one n-wide Winograd input tile per column step (stride m).
//  Downstream handshake is valid/ready. Buffer pointers are cleared between bands.
//  Sits between the pixel source and the Winograd transform stage; line_buffer.o_data is the tile payload.
// PARAMETERS
//  M          3    channels (rows) held per band; matches line_buffer M
//  W          512  pixels per row; matches line_buffer W
//  n          4    input tile width; matches line_buffer n
//  m          2    output tile size / column stride; matches line_buffer m
//  NUM_BANDS  4    row bands per frame (>=1)
//  Derived: TILES = (W-n)/m + 1 (integer floor), FILL = M*W
// PORTS
//  i_clk           in   1   clock; all logic on rising edge
//  i_rst           in   1   synchronous reset, active-high
//  i_start         in   1   start-of-frame pulse; honoured only in IDLE
//  i_pix_valid     in   1   upstream pixel strobe
//  o_pix_ready     out  1   upstream may transfer (high only in FILL)
//  o_lb_data_valid out  1   to line_buffer.i_data_valid = i_pix_valid & o_pix_ready
//  o_lb_rst        out  1   to line_buffer.i_rst = i_rst | (state==CLEAR)
//  o_lb_rd_adv     out  1   to line_buffer.output_needs_to_be_read = o_tile_valid & i_tile_ready
//  o_tile_valid    out  1   line_buffer.o_data holds a valid tile (high only in ISSUE)
//  i_tile_ready    in   1   downstream accepts tile
//  o_tile_col      out  $clog2(TILES+1)     index of current tile in band, 0..TILES-1
//  o_band_idx      out  $clog2(NUM_BANDS+1) current band, 0..NUM_BANDS-1
//  o_band_done     out  1   1-cycle pulse in CLEAR
//  o_frame_done    out  1   1-cycle pulse in CLEAR of last band
//  o_busy          out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; fill_cnt, o_tile_col and o_band_idx = 0; all other outputs 0 except o_lb_rst (1 while i_rst high).
//  Reset mid-operation aborts the band immediately. No tile or pixel handshake completes in the reset cycle.
//  FSM states: IDLE, FILL, ISSUE, CLEAR.
//   IDLE : i_start -> FILL, band_idx=0. Other inputs ignored.
//   FILL : each cycle with i_pix_valid, one pixel is written and fill_cnt increments.
//          On the write with fill_cnt==FILL-1 -> ISSUE, fill_cnt=0.
//   ISSUE: o_tile_valid=1. Tile data is combinational from line_buffer, so it is valid in the same cycle.
//          On each valid&ready: rd_adv pulses and tile_col increments. Peak throughput is 1 tile/cycle.
//          On valid&ready with tile_col==TILES-1 -> CLEAR, tile_col=0.
//          ready low: hold; tile_col and rdPntr are unchanged.
//   CLEAR: one cycle; o_lb_rst=1 and o_band_done=1.
//          If band_idx==NUM_BANDS-1: o_frame_done=1, band_idx=0 -> IDLE.
//          Else: band_idx+1 -> FILL.
//  o_pix_ready is 0 in IDLE/ISSUE/CLEAR. Upstream pixels are not consumed there.
//  i_start outside IDLE is ignored (no restart, no queueing).
//  i_start and i_rst in the same cycle: reset wins.
//  Counters never wrap. fill_cnt max FILL-1; tile_col max TILES-1.
//  Because o_lb_rst re-zeros both line_buffer pointers each band, line_buffer pointer wrap is never exercised.
//  Widths: fill_cnt is $clog2(FILL+1) bits. Compare against localparam constants; no truncation.
// TESTING (bench params M=3, W=8, n=4, m=2, NUM_BANDS=2 -> TILES=3, FILL=24)
//  1. Reset, start, 24 back-to-back pixels 0..23, ready=1
//     -> ISSUE the cycle after pixel 23.
//     -> tiles {0,1,2,3 | 8..11 | 16..19}, {2..5 | 10..13 | 18..21}, {4..7 | 12..15 | 20..23} on 3 consecutive cycles.
//     -> band_done pulse follows.
//  2. Same stimulus, ready toggled 0/1 each cycle
//     -> each tile held until accepted, tile_col 0,1,2.
//     -> exactly 3 rd_adv pulses.
//  3. Full frame of 2 bands
//     -> o_lb_rst pulses once between bands; band 2 tiles start at address 0.
//     -> frame_done in band 2 CLEAR; then IDLE, busy=0.
//  4. i_pix_valid gaps during FILL plus pixels offered during ISSUE
//     -> only 24 writes per band.
//     -> pix_ready=0 outside FILL.
//  5. i_rst asserted after 10 pixels, then restart
//     -> IDLE, o_lb_rst=1 during reset, counters zero.
//     -> next band fills the full 24 pixels afresh.
//  6. i_start pulsed during FILL and ISSUE
//     -> no effect on state or counters.

Source files
------------

// File: rtl/line_buffer_tile_ctrl_if.sv
// Handshake bundle between the tile controller and its neighbours.
// Carries the upstream pixel strobe/ready, the line_buffer write and
// read-advance strobes, and the downstream tile valid/ready with the tile index.
interface line_buffer_tile_ctrl_if #(
    parameter int COL_W = 8
);
    logic             i_pix_valid;
    logic             o_pix_ready;
    logic             o_lb_data_valid;
    logic             o_lb_rd_adv;
    logic             o_tile_valid;
    logic             i_tile_ready;
    logic [COL_W-1:0] o_tile_col;

    // Controller side: consumes the strobes, drives the handshakes.
    modport master (
        input  i_pix_valid,
        input  i_tile_ready,
        output o_pix_ready,
        output o_lb_data_valid,
        output o_lb_rd_adv,
        output o_tile_valid,
        output o_tile_col
    );

    // Environment side: pixel source, line_buffer and transform stage.
    modport slave (
        output i_pix_valid,
        output i_tile_ready,
        input  o_pix_ready,
        input  o_lb_data_valid,
        input  o_lb_rd_adv,
        input  o_tile_valid,
        input  o_tile_col
    );
endinterface

// File: rtl/line_buffer_tile_ctrl.sv
// Band sequencer for one line_buffer instance.
// Each band fills the buffer with M*W pixels, then issues one n-wide
// Winograd input tile per column step of m, then clears the buffer pointers
// before the next band. After NUM_BANDS bands the frame is done.
module line_buffer_tile_ctrl #(
    parameter int M         = 3,
    parameter int W         = 512,
    parameter int n         = 4,
    parameter int m         = 2,
    parameter int NUM_BANDS = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    line_buffer_tile_ctrl_if.master          bus,
    output logic                             o_lb_rst,
    output logic [$clog2(NUM_BANDS+1)-1:0]   o_band_idx,
    output logic                             o_band_done,
    output logic                             o_frame_done,
    output logic                             o_busy
);

    localparam int TILES  = (W - n) / m + 1;
    localparam int FILL   = M * W;
    localparam int COL_W  = $clog2(TILES + 1);
    localparam int BAND_W = $clog2(NUM_BANDS + 1);
    localparam int FILL_W = $clog2(FILL + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL - 1);
    localparam logic [COL_W-1:0]  TILE_LAST = COL_W'(TILES - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BANDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [COL_W-1:0]    tile_col_q, tile_col_d;
    logic [BAND_W-1:0]   band_idx_q, band_idx_d;

    logic run;
    logic pix_fire;
    logic tile_fire;

    // Everything handshake-related is suppressed in the reset cycle so no
    // pixel or tile transfer can complete while the band is being aborted.
    assign run = ~i_rst;

    // Transfers that actually complete this cycle.
    always_comb begin
        pix_fire  = run & (state_q == ST_FILL)  & bus.i_pix_valid;
        tile_fire = run & (state_q == ST_ISSUE) & bus.i_tile_ready;
    end

    // State and counter registers; reset returns to an idle, zeroed controller.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            tile_col_q <= '0;
            band_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            tile_col_q <= tile_col_d;
            band_idx_q <= band_idx_d;
        end
    end

    // Next-state and counter update: fill, issue tiles, clear, next band.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        tile_col_d = tile_col_q;
        band_idx_d = band_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_FILL;
                    fill_cnt_d = '0;
                    tile_col_d = '0;
                    band_idx_d = '0;
                end
            end

            ST_FILL: begin
                if (pix_fire) begin
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d    = ST_ISSUE;
                        fill_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    end
                end
            end

            ST_ISSUE: begin
                if (tile_fire) begin
                    if (tile_col_q == TILE_LAST) begin
                        state_d    = ST_CLEAR;
                        tile_col_d = '0;
                    end else begin
                        tile_col_d = tile_col_q + COL_W'(1);
                    end
                end
            end

            ST_CLEAR: begin
                fill_cnt_d = '0;
                tile_col_d = '0;
                if (band_idx_q == BAND_LAST) begin
                    state_d    = ST_IDLE;
                    band_idx_d = '0;
                end else begin
                    state_d    = ST_FILL;
                    band_idx_d = band_idx_q + BAND_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state; the buffer reset also follows i_rst.
    always_comb begin
        bus.o_pix_ready     = run & (state_q == ST_FILL);
        bus.o_lb_data_valid = pix_fire;
        bus.o_tile_valid    = run & (state_q == ST_ISSUE);
        bus.o_lb_rd_adv     = tile_fire;
        bus.o_tile_col      = tile_col_q & {COL_W{run}};

        o_lb_rst     = i_rst | (state_q == ST_CLEAR);
        o_band_done  = run & (state_q == ST_CLEAR);
        o_frame_done = run & (state_q == ST_CLEAR) & (band_idx_q == BAND_LAST);
        o_busy       = run & (state_q != ST_IDLE);
        o_band_idx   = band_idx_q & {BAND_W{run}};
    end

endmodule

// File: tb/tb_line_buffer_tile_ctrl.sv
// Self-checking bench for line_buffer_tile_ctrl (M=3, W=8, n=4, m=2, 2 bands).
// A band/frame model counts accepted pixels and tiles and derives the
// expected outputs from those counts; a small line_buffer stand-in driven by
// the DUT strobes provides the tile payload that is checked against the model.
module tb_line_buffer_tile_ctrl;

    localparam int M      = 3;
    localparam int W      = 8;
    localparam int N      = 4;
    localparam int MS     = 2;
    localparam int NB     = 2;
    localparam int TILES  = (W - N) / MS + 1;
    localparam int FILL   = M * W;
    localparam int COL_W  = $clog2(TILES + 1);
    localparam int BAND_W = $clog2(NB + 1);

    localparam logic [95:0] LIT_T0   = 96'h131211100B0A090803020100;
    localparam logic [95:0] LIT_T1   = 96'h151413120D0C0B0A05040302;
    localparam logic [95:0] LIT_T2   = 96'h171615140F0E0D0C07060504;
    localparam logic [95:0] LIT_B100 = 96'h777675746F6E6D6C67666564;
    localparam logic [95:0] LIT_B50  = 96'h454443423D3C3B3A35343332;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        pix_data = 8'd0;
    logic              lb_rst;
    logic [BAND_W-1:0] band_idx;
    logic              band_done;
    logic              frame_done;
    logic              busy;
    bit                chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    line_buffer_tile_ctrl_if #(.COL_W(COL_W)) bus ();

    line_buffer_tile_ctrl #(
        .M(M), .W(W), .n(N), .m(MS), .NUM_BANDS(NB)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .bus          (bus),
        .o_lb_rst     (lb_rst),
        .o_band_idx   (band_idx),
        .o_band_done  (band_done),
        .o_frame_done (frame_done),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: frame active flag plus per-band pixel/tile counts.
    bit         m_active  = 1'b0;
    int         m_writes  = 0;
    int         m_accepts = 0;
    int         m_band    = 0;
    logic [7:0] m_pix [FILL];

    // Line buffer stand-in driven only by the DUT strobes.
    logic [7:0] lb_mem [FILL];
    int         lb_wr = 0;
    int         lb_rd = 0;
    logic       s_lb_rst = 1'b1;
    logic       s_dv = 1'b0;
    logic       s_adv = 1'b0;
    logic [7:0] s_data = 8'd0;

    // 0 idle, 1 filling, 2 issuing tiles, 3 clearing
    function automatic int m_phase();
        if (!m_active)         return 0;
        if (m_writes < FILL)   return 1;
        if (m_accepts < TILES) return 2;
        return 3;
    endfunction

    function automatic logic [95:0] model_tile();
        logic [95:0] t = '0;
        for (int c = 0; c < M; c++)
            for (int k = 0; k < N; k++)
                t[(c*N+k)*8 +: 8] = m_pix[c*W + m_accepts*MS + k];
        return t;
    endfunction

    function automatic logic [95:0] lb_tile();
        logic [95:0] t = '0;
        int idx;
        for (int c = 0; c < M; c++)
            for (int k = 0; k < N; k++) begin
                idx = c*W + lb_rd*MS + k;
                t[(c*N+k)*8 +: 8] = (idx < FILL) ? lb_mem[idx] : 8'hEE;
            end
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill one band with pixels base, base+1, ...; optional valid gaps.
    task automatic applyStimulus(input int base, input bit gaps);
        int w = 0;
        for (int j = 0; j < 200 && w < FILL; j++) begin
            bus.i_pix_valid = !(gaps && (j % 3 == 2));
            pix_data = 8'(base + w);
            tick();
            if (bus.i_pix_valid) w++;
        end
        bus.i_pix_valid = 1'b0;
        checkOutput("fill_bound", 96'(w), 96'(FILL));
    endtask

    // Model update on the active edge from the (stable) inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_active  <= 1'b0;
            m_writes  <= 0;
            m_accepts <= 0;
            m_band    <= 0;
        end else begin
            case (m_phase())
                0: if (start) begin
                    m_active  <= 1'b1;
                    m_writes  <= 0;
                    m_accepts <= 0;
                    m_band    <= 0;
                end
                1: if (bus.i_pix_valid) begin
                    m_pix[m_writes] <= pix_data;
                    m_writes        <= m_writes + 1;
                end
                2: if (bus.i_tile_ready) m_accepts <= m_accepts + 1;
                default: begin
                    if (m_band == NB - 1) begin
                        m_active <= 1'b0;
                        m_band   <= 0;
                    end else begin
                        m_band <= m_band + 1;
                    end
                    m_writes  <= 0;
                    m_accepts <= 0;
                end
            endcase
        end
    end

    // Line buffer stand-in update from strobes captured on the falling edge.
    always @(posedge clk) begin
        if (s_lb_rst) begin
            lb_wr <= 0;
            lb_rd <= 0;
        end else begin
            if (s_dv) begin
                if (lb_wr < FILL) lb_mem[lb_wr] <= s_data;
                lb_wr <= lb_wr + 1;
            end
            if (s_adv) lb_rd <= lb_rd + 1;
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        s_lb_rst <= lb_rst;
        s_dv     <= bus.o_lb_data_valid;
        s_adv    <= bus.o_lb_rd_adv;
        s_data   <= pix_data;
        if (chk_en) begin
            checkOutput("cmp_pix_ready", 96'(bus.o_pix_ready), 96'(!rst && m_phase() == 1));
            checkOutput("cmp_lb_dv", 96'(bus.o_lb_data_valid), 96'(!rst && m_phase() == 1 && bus.i_pix_valid));
            checkOutput("cmp_tile_valid", 96'(bus.o_tile_valid), 96'(!rst && m_phase() == 2));
            checkOutput("cmp_rd_adv", 96'(bus.o_lb_rd_adv), 96'(!rst && m_phase() == 2 && bus.i_tile_ready));
            checkOutput("cmp_lb_rst", 96'(lb_rst), 96'(rst || m_phase() == 3));
            checkOutput("cmp_band_done", 96'(band_done), 96'(!rst && m_phase() == 3));
            checkOutput("cmp_frame_done", 96'(frame_done), 96'(!rst && m_phase() == 3 && m_band == NB - 1));
            checkOutput("cmp_busy", 96'(busy), 96'(!rst && m_active));
            checkOutput("cmp_tile_col", 96'(bus.o_tile_col), 96'((!rst && m_phase() == 2) ? m_accepts : 0));
            checkOutput("cmp_band_idx", 96'(band_idx), 96'(!rst ? m_band : 0));
            if (!rst && m_phase() == 2)
                checkOutput("cmp_tile_data", lb_tile(), model_tile());
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int  adv;
        int  rst_pulses;
        bit  seen_done;

        bus.i_pix_valid  = 1'b0;
        bus.i_tile_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("reset_lb_rst", 96'(lb_rst), 96'(1));
        checkOutput("reset_busy", 96'(busy), 96'(0));
        rst = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("idle_tile_col", 96'(bus.o_tile_col), 96'(0));
        checkOutput("idle_lb_rst", 96'(lb_rst), 96'(0));

        // Band 0: back-to-back pixels 0..23, ready held high.
        $display("[TB] scenario 1: straight fill and issue");
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.i_tile_ready = 1'b1;
        applyStimulus(0, 1'b0);
        @(negedge clk);
        checkOutput("t1_issue_after_fill", 96'(bus.o_tile_valid), 96'(1));
        checkOutput("t1_tile0", lb_tile(), LIT_T0);
        checkOutput("t1_model_tile0", model_tile(), LIT_T0);
        tick();
        @(negedge clk);
        checkOutput("t1_col1", 96'(bus.o_tile_col), 96'(1));
        checkOutput("t1_tile1", lb_tile(), LIT_T1);
        tick();
        @(negedge clk);
        checkOutput("t1_col2", 96'(bus.o_tile_col), 96'(2));
        checkOutput("t1_tile2", lb_tile(), LIT_T2);
        checkOutput("t1_model_tile2", model_tile(), LIT_T2);
        tick();
        @(negedge clk);
        checkOutput("t1_band_done", 96'(band_done), 96'(1));
        checkOutput("t1_not_frame_done", 96'(frame_done), 96'(0));
        checkOutput("t1_writes", 96'(lb_wr), 96'(24));
        bus.i_tile_ready = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("t3_band1_idx", 96'(band_idx), 96'(1));
        checkOutput("t3_band1_ptr0", 96'(lb_wr), 96'(0));

        // Band 1: valid gaps, start pulse in FILL, ready toggling in ISSUE.
        $display("[TB] scenario 2-4,6: gaps, toggled ready, second band");
        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(100, 1'b1);
        bus.i_pix_valid = 1'b1;
        pix_data = 8'hAA;
        adv = 0;
        rst_pulses = 0;
        seen_done = 1'b0;
        for (int j = 0; j < 40 && !seen_done; j++) begin
            bus.i_tile_ready = (j % 2 == 1);
            start = (j == 3);
            @(negedge clk);
            if (lb_rst) rst_pulses++;
            if (bus.o_lb_rd_adv) begin
                if (adv == 0) checkOutput("t3_band1_tile0", lb_tile(), LIT_B100);
                checkOutput("t2_col_order", 96'(bus.o_tile_col), 96'(adv));
                adv++;
            end
            if (band_done) begin
                seen_done = 1'b1;
                checkOutput("t3_frame_done", 96'(frame_done), 96'(1));
                checkOutput("t4_writes", 96'(lb_wr), 96'(24));
            end
            tick();
        end
        start = 1'b0;
        checkOutput("t2_band_done_seen", 96'(seen_done), 96'(1));
        checkOutput("t2_adv_count", 96'(adv), 96'(3));
        checkOutput("t3_lb_rst_once", 96'(rst_pulses), 96'(1));
        @(negedge clk);
        checkOutput("t3_idle_busy", 96'(busy), 96'(0));
        checkOutput("t4_idle_pix_ready", 96'(bus.o_pix_ready), 96'(0));
        bus.i_pix_valid = 1'b0;

        // Reset after 10 pixels, then start+reset together, then restart.
        $display("[TB] scenario 5: abort by reset and restart");
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.i_pix_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pix_data = 8'(i);
            tick();
        end
        bus.i_pix_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_lb_rst", 96'(lb_rst), 96'(1));
        checkOutput("t5_busy_in_rst", 96'(busy), 96'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_idle_after_rst", 96'(busy), 96'(0));
        checkOutput("t5_band_zero", 96'(band_idx), 96'(0));
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("t5_reset_wins", 96'(busy), 96'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.i_tile_ready = 1'b1;
        applyStimulus(50, 1'b0);
        @(negedge clk);
        checkOutput("t5_fresh_tile0", lb_tile(), LIT_B50);
        checkOutput("t5_fresh_writes", 96'(lb_wr), 96'(24));
        tick();
        tick();
        tick();
        @(negedge clk);
        checkOutput("t5_band_done", 96'(band_done), 96'(1));
        checkOutput("t5_band0_no_frame", 96'(frame_done), 96'(0));
        bus.i_tile_ready = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("t5_next_band", 96'(band_idx), 96'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
